// File: rtl/trellis_tx.sv
// Two-stage 4D-PAM5 trellis transmit pipeline: byte -> coded byte + parity (S1) -> four PAM-5 symbols (S2).
// Optional side-stream scrambler is enabled by defining TRELLIS_TX_SCRAMBLER_EN.
module trellis_tx (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        io_txData,
    input  logic              io_txValid,
    output logic              io_txReady,
    output logic signed [2:0] io_txSymbols_0,
    output logic signed [2:0] io_txSymbols_1,
    output logic signed [2:0] io_txSymbols_2,
    output logic signed [2:0] io_txSymbols_3,
    output logic              io_txSymValid,
    input  logic              io_symReady
);

    logic             s1_valid;
    logic             s1_parity;
    logic [7:0]       s1_data;
    logic             s2_valid;
    logic [3:0][2:0]  s2_sym;
    logic [2:0]       cs;
    logic [7:0]       coded;
    logic [3:0][2:0]  mapped;
    logic             s2_advance;
    logic             accept;

    assign s2_advance = !s2_valid || io_symReady;
    // Reset term keeps the handshake closed while reset is held.
    assign io_txReady = reset && (!s1_valid || s2_advance);
    assign accept     = io_txValid && io_txReady;

`ifdef TRELLIS_TX_SCRAMBLER_EN
    logic [10:0] lfsr;

    assign coded = io_txData ^ lfsr[7:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= 11'h7FF;
        end else if (accept) begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
        end
    end
`else
    assign coded = io_txData;
`endif

    function automatic logic [2:0] pam_level(input logic [1:0] bits);
        logic [2:0] level;
        case (bits)
            2'b00:   level = 3'b110;
            2'b01:   level = 3'b111;
            2'b10:   level = 3'b001;
            default: level = 3'b010;
        endcase
        return level;
    endfunction

    always_comb begin
        mapped = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            mapped[j] = pam_level(s1_data[2*j +: 2]);
        end
        if (s1_parity) begin
            mapped[0] = -mapped[0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_parity <= 1'b0;
            s1_data   <= '0;
            s2_valid  <= 1'b0;
            s2_sym    <= '0;
            cs        <= '0;
        end else begin
            if (s2_advance) begin
                s2_valid <= s1_valid;
                s2_sym   <= mapped;
            end
            // S1 is free whenever io_txReady is high, so it reloads (or empties) then.
            if (io_txReady) begin
                s1_valid <= io_txValid;
            end
            if (accept) begin
                s1_data   <= coded;
                s1_parity <= cs[0];
                cs        <= {coded[7] ^ cs[1], coded[6] ^ cs[0], cs[2]};
            end
        end
    end

    assign io_txSymValid  = s2_valid;
    assign io_txSymbols_0 = s2_valid ? s2_sym[0] : '0;
    assign io_txSymbols_1 = s2_valid ? s2_sym[1] : '0;
    assign io_txSymbols_2 = s2_valid ? s2_sym[2] : '0;
    assign io_txSymbols_3 = s2_valid ? s2_sym[3] : '0;

endmodule

// File: tb/tb_trellis_tx.sv
// Scoreboard bench for trellis_tx: driver pushes expected symbol sets, a negedge monitor pops and compares.
module tb_trellis_tx;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic signed [2:0] sym0, sym1, sym2, sym3;
    logic              sym_valid;
    logic              sym_ready;
    logic [11:0]       sym_bus;

    int checks   = 0;
    int failures = 0;

    logic [11:0] sb_q[$];
    logic [2:0]  m_cs;
    logic [10:0] m_lfsr;

    trellis_tx dut (
        .clock          (clock),
        .reset          (reset),
        .io_txData      (tx_data),
        .io_txValid     (tx_valid),
        .io_txReady     (tx_ready),
        .io_txSymbols_0 (sym0),
        .io_txSymbols_1 (sym1),
        .io_txSymbols_2 (sym2),
        .io_txSymbols_3 (sym3),
        .io_txSymValid  (sym_valid),
        .io_symReady    (sym_ready)
    );

    always #5 clock = ~clock;

    assign sym_bus = {sym3, sym2, sym1, sym0};

    function automatic int lvl(input logic [1:0] b);
        return (b < 2'd2) ? int'(b) - 2 : int'(b) - 1;
    endfunction

    function automatic logic [11:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [7:0] d;
        int v0;
        d = b;
`ifdef TRELLIS_TX_SCRAMBLER_EN
        d = b ^ m_lfsr[7:0];
        m_lfsr = {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
`endif
        v0 = lvl(d[1:0]);
        if (m_cs[0]) v0 = -v0;
        sb_q.push_back(pk(v0, lvl(d[3:2]), lvl(d[5:4]), lvl(d[7:6])));
        m_cs = {d[7] ^ m_cs[1], d[6] ^ m_cs[0], m_cs[2]};
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic drive_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tx_ready) begin
                model_accept(b);
                @(posedge clock); #1;
                tx_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
        tx_valid = 1'b0;
    endtask

    logic [11:0] held;
    logic        stalled = 1'b0;
    logic [11:0] exp_sym;

    always @(negedge clock) begin
        if (!reset) begin
            stalled = 1'b0;
        end else if (sym_valid) begin
            if (stalled) check("stall_hold", 32'(sym_bus), 32'(held));
            if (sym_ready) begin
                stalled = 1'b0;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_symbols: got %h expected none", sym_bus);
                end else begin
                    exp_sym = sb_q.pop_front();
                    check("symbols", 32'(sym_bus), 32'(exp_sym));
                end
            end else begin
                stalled = 1'b1;
                held    = sym_bus;
            end
        end else begin
            if (stalled) begin
                checks++;
                failures++;
                $display("FAIL stall_drop: valid 0 expected 1");
            end
            stalled = 1'b0;
            check("idle_zero", 32'(sym_bus), 32'h0);
        end
    end

    logic [7:0] stall_bytes [5]  = '{8'h3C, 8'hE1, 8'h07, 8'h99, 8'h42};
    logic [7:0] mix_bytes   [12] = '{8'hFF, 8'h80, 8'h01, 8'h6D, 8'hB2, 8'h00,
                                     8'h5A, 8'hC3, 8'h1B, 8'h7E, 8'h24, 8'hF0};
    logic [23:0] ready_pat = 24'b1011_0011_1101_0110_1110_0101;

    initial begin
        reset     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        sym_ready = 1'b1;
        m_cs      = '0;
        m_lfsr    = 11'h7FF;

        @(posedge clock); #1;
        @(negedge clock);
        check("rst_ready", 32'(tx_ready), 32'h0);
        check("rst_valid", 32'(sym_valid), 32'h0);
        check("rst_syms", 32'(sym_bus), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

`ifndef TRELLIS_TX_SCRAMBLER_EN
        tx_valid = 1'b1;
        tx_data  = 8'h1B;
        @(negedge clock);
        check("dir_ready0", 32'(tx_ready), 32'h1);
        model_accept(8'h1B);
        @(posedge clock); #1;
        tx_data = 8'hC0;
        @(negedge clock);
        check("dir_lat_cyc1", 32'(sym_valid), 32'h0);
        check("dir_ready1", 32'(tx_ready), 32'h1);
        model_accept(8'hC0);
        @(posedge clock); #1;
        tx_data = 8'h00;
        @(negedge clock);
        check("dir_sym_1b", 32'(sym_bus), 32'(pk(2, 1, -1, -2)));
        check("dir_cs_c0", 32'(dut.cs), 32'h6);
        model_accept(8'h00);
        @(posedge clock); #1;
        tx_data = 8'h00;
        @(negedge clock);
        check("dir_sym_c0", 32'(sym_bus), 32'(pk(-2, -2, -2, 2)));
        check("dir_cs_3rd", 32'(dut.cs), 32'h5);
        model_accept(8'h00);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        @(negedge clock);
        check("dir_sym_00a", 32'(sym_bus), 32'(pk(-2, -2, -2, -2)));
        @(posedge clock); #1;
        @(negedge clock);
        check("dir_sym_00b", 32'(sym_bus), 32'(pk(2, -2, -2, -2)));
        @(posedge clock); #1;
`else
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clock);
        check("scr_ready0", 32'(tx_ready), 32'h1);
        model_accept(8'h00);
        @(posedge clock); #1;
        tx_valid = 1'b0;
        @(negedge clock);
        check("scr_lfsr", 32'(dut.lfsr), 32'h7FE);
        @(posedge clock); #1;
        @(negedge clock);
        check("scr_sym", 32'(sym_bus), 32'(pk(2, 2, 2, 2)));
        @(posedge clock); #1;
`endif

        repeat (3) begin @(posedge clock); #1; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("idle_valid", 32'(sym_valid), 32'h0);
            check("idle_syms", 32'(sym_bus), 32'h0);
            check("idle_cs", 32'(dut.cs), 32'(m_cs));
            @(posedge clock); #1;
        end

        fork
            begin
                for (int i = 0; i < 5; i++) drive_byte(stall_bytes[i]);
            end
            begin
                sym_ready = 1'b0;
                @(negedge clock);
                @(posedge clock); #1;
                @(negedge clock);
                @(posedge clock); #1;
                @(negedge clock);
                check("stall_ready", 32'(tx_ready), 32'h0);
                check("stall_valid", 32'(sym_valid), 32'h1);
                @(posedge clock); #1;
                sym_ready = 1'b1;
            end
        join

        fork
            begin
                for (int i = 0; i < 12; i++) drive_byte(mix_bytes[i]);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    sym_ready = ready_pat[i];
                    @(posedge clock); #1;
                end
                sym_ready = 1'b1;
            end
        join
        sym_ready = 1'b1;

        for (int i = 0; i < 30 && (sb_q.size() != 0 || sym_valid); i++) begin
            @(posedge clock); #1;
        end
        check("drain_before_rst", 32'(sb_q.size()), 32'h0);

        drive_byte(8'h5A);
        drive_byte(8'hA5);
        reset    = 1'b0;
        m_cs     = '0;
        m_lfsr   = 11'h7FF;
        @(negedge clock);
        check("midrst_ready", 32'(tx_ready), 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        sb_q.delete();
        @(negedge clock);
        check("midrst_valid", 32'(sym_valid), 32'h0);
        check("midrst_syms", 32'(sym_bus), 32'h0);
        @(posedge clock); #1;
        drive_byte(8'h1B);
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("resend_valid", 32'(sym_valid), 32'h1);
`ifndef TRELLIS_TX_SCRAMBLER_EN
        check("resend_sym", 32'(sym_bus), 32'(pk(2, 1, -1, -2)));
`endif
        @(posedge clock); #1;

        for (int i = 0; i < 30 && (sb_q.size() != 0 || sym_valid); i++) begin
            @(posedge clock); #1;
        end
        check("final_drain", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trellis_tx.md
TRELLIS_TX -- requirements
Module: trellis_tx

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port io_txData, input, 8 bits: payload byte to transmit.
REQ-004 SHALL have port io_txValid, input, 1 bit: io_txData holds a valid byte.
REQ-005 SHALL have port io_txReady, output, 1 bit: block accepts a byte this cycle.
REQ-006 SHALL have ports io_txSymbols_0..io_txSymbols_3, outputs, 3 bits signed each: PAM-5 level per wire pair, range -2..+2.
REQ-007 SHALL have port io_txSymValid, output, 1 bit: symbols carry an encoded byte.
REQ-008 SHALL have port io_symReady, input, 1 bit: downstream line driver consumes the symbols this cycle.

Function
REQ-009 SHALL accept a byte on any cycle where io_txValid and io_txReady are both high; no acceptance otherwise.
REQ-010 SHALL use a two-stage pipeline: S1 holds the coded byte and parity bit; S2 holds the mapped symbols.
REQ-011 SHALL present the symbols of an accepted byte on the outputs exactly 2 cycles after acceptance when io_symReady stays high.
REQ-012 SHALL stall S2 while io_txSymValid=1 and io_symReady=0: outputs held stable, no byte lost or duplicated.
REQ-013 SHALL drive io_txReady = !S1valid || S2 advances this cycle (S2 advances = !S2valid || io_symReady); io_txReady is combinational from state and io_symReady only, never from io_txValid.
REQ-014 SHALL hold a 3-bit encoder state cs[2:0]; per byte moved into S1, parity p = cs[0], then cs <= {d[7]^cs[1], d[6]^cs[0], cs[2]} (bit order [2],[1],[0]), where d is the coded byte.
REQ-015 SHALL leave cs unchanged on cycles where no byte enters S1.
REQ-016 SHALL map pair j from bits d[2j+1:2j]: 00 -> -2, 01 -> -1, 10 -> +1, 11 -> +2.
REQ-017 SHALL negate the pair-0 level when p=1; pairs 1..3 are unaffected by p.
REQ-018 SHALL drive all four symbols to 0 whenever io_txSymValid=0 (idle line).
REQ-019 SHALL, on simultaneous S2 consume and S1 advance, move S1 into S2 and a newly accepted byte into S1 in the same cycle (full throughput: one byte per cycle).

Reset
REQ-020 SHALL, while reset=0 at a clock edge, clear S1valid, S2valid, cs to 0, and load the scrambler to its seed.
REQ-021 SHALL hold io_txReady=0 while reset=0; io_txSymValid=0 and all symbols 0 from the first edge with reset=0.
REQ-022 SHALL discard any in-flight bytes on reset asserted mid-stream; after release, the first accepted byte uses cs=0 and the scrambler seed.

Configuration
REQ-023 SHALL, with macro TRELLIS_TX_SCRAMBLER_EN defined, implement an 11-bit LFSR with seed 11'h7FF: d = io_txData ^ lfsr[7:0]; on each acceptance lfsr <= {lfsr[9:0], lfsr[10]^lfsr[8]}.
REQ-024 SHALL, without TRELLIS_TX_SCRAMBLER_EN, use d = io_txData with no LFSR hardware; all other behaviour is identical.

Verification
REQ-025 SHALL cover, scrambler off, reset, io_symReady=1, bytes 0x1B, 0xC0, 0x00, 0x00 on consecutive cycles -> symbols (+2,+1,-1,-2), (-2,-2,-2,+2), (-2,-2,-2,-2), (+2,-2,-2,-2) on cycles 2..5 after the first acceptance, cs=3'b110 after 0xC0 and 3'b101 after the third byte.
REQ-026 SHALL cover, scrambler on, first byte 0x00 after reset -> mask 0xFF, symbols (+2,+2,+2,+2), lfsr=11'h7FE after acceptance.
REQ-027 SHALL cover holding io_symReady=0 for 3 cycles with io_txValid=1 -> outputs frozen, io_txReady=0 once S1 and S2 are full, no byte dropped after release.
REQ-028 SHALL cover io_txValid=0 for 4 cycles -> io_txSymValid=0, symbols all 0, cs unchanged.
REQ-029 SHALL cover asserting reset for 1 cycle mid-stream with 2 bytes in flight -> io_txSymValid=0 on the next cycle; resending 0x1B yields (+2,+1,-1,-2).
